// File: rtl/count_step_monitor.sv
// count_step_monitor: watches an up/down counter and checks every step is +1, -1 or hold.
// Latency: all outputs registered, they reflect the step seen at edge k during cycle k+1.
// Backpressure: none; passive observer sampling count/upordown on every clock.
//
// Ports:
//   clk, reset      - clock shared with the counter; async active-low reset
//   cnt_reset       - the counter's own reset; re-arms the monitor and suppresses checks
//   upordown, count - counter direction (1 = up) and value under observation
//   clear           - synchronous clear of wrap_count / step_err (and min/max when enabled)
//   wrap_up/down    - one-cycle wrap pulses (MAX->0 / 0->MAX)
//   wrap_count      - saturating wrap tally, step_err - sticky illegal-step flag
//   armed           - a previous sample is held and steps are being checked
// Optional: define MONITOR_MINMAX_EN to add min_seen / max_seen outputs.
module count_step_monitor #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cnt_reset,
  input  logic              upordown,
  input  logic [WIDTH-1:0]  count,
  input  logic              clear,
  output logic              wrap_up,
  output logic              wrap_down,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_err,
  output logic              armed
`ifdef MONITOR_MINMAX_EN
  ,
  output logic [WIDTH-1:0]  min_seen,
  output logic [WIDTH-1:0]  max_seen
`endif
);

  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [WIDTH-1:0]  CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_count_q, prev_count_d;
  logic                prev_dir_q, prev_dir_d;
  logic                wrap_up_q, wrap_up_d;
  logic                wrap_down_q, wrap_down_d;
  logic [WRAP_W-1:0]   wrap_count_q, wrap_count_d;
  logic                step_err_q, step_err_d;
`ifdef MONITOR_MINMAX_EN
  logic [WIDTH-1:0]    min_seen_q, min_seen_d;
  logic [WIDTH-1:0]    max_seen_q, max_seen_d;
`endif

  // Step classification against the previous sample. The direction that
  // produced the step is prev_dir, not the current upordown.
  logic [WIDTH-1:0] cnt_inc, cnt_dec;
  logic             step_up_ok, step_dn_ok, step_hold, hit_up, hit_dn;

  always_comb begin
    cnt_inc    = prev_count_q + CNT_ONE;
    cnt_dec    = prev_count_q - CNT_ONE;
    step_hold  = (count == prev_count_q);
    step_up_ok = prev_dir_q  && (count == cnt_inc);
    step_dn_ok = !prev_dir_q && (count == cnt_dec);
    hit_up     = step_up_ok && (prev_count_q == CNT_MAX);
    hit_dn     = step_dn_ok && (prev_count_q == '0);
  end

  always_comb begin
    state_d      = state_q;
    prev_count_d = prev_count_q;
    prev_dir_d   = prev_dir_q;
    wrap_up_d    = 1'b0;
    wrap_down_d  = 1'b0;
    wrap_count_d = wrap_count_q;
    step_err_d   = step_err_q;
`ifdef MONITOR_MINMAX_EN
    min_seen_d   = min_seen_q;
    max_seen_d   = max_seen_q;
`endif

    // A counter reset always re-arms and is never judged as a step.
    if (cnt_reset) begin
      state_d = IDLE;
    end else begin
      state_d      = TRACK;
      prev_count_d = count;
      prev_dir_d   = upordown;
      if (state_q == TRACK) begin
        if (!(step_up_ok || step_dn_ok || step_hold)) begin
          step_err_d = 1'b1;
        end
        wrap_up_d   = hit_up;
        wrap_down_d = hit_dn;
        if ((hit_up || hit_dn) && (wrap_count_q != WRAP_MAX)) begin
          wrap_count_d = wrap_count_q + WRAP_ONE;
        end
      end
`ifdef MONITOR_MINMAX_EN
      if (count < min_seen_q) min_seen_d = count;
      if (count > max_seen_q) max_seen_d = count;
`endif
    end

    // clear overrides anything detected on the same edge; pulses still go out.
    if (clear) begin
      wrap_count_d = '0;
      step_err_d   = 1'b0;
`ifdef MONITOR_MINMAX_EN
      min_seen_d   = CNT_MAX;
      max_seen_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      prev_count_q <= '0;
      prev_dir_q   <= 1'b0;
      wrap_up_q    <= 1'b0;
      wrap_down_q  <= 1'b0;
      wrap_count_q <= '0;
      step_err_q   <= 1'b0;
`ifdef MONITOR_MINMAX_EN
      min_seen_q   <= CNT_MAX;
      max_seen_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      prev_count_q <= prev_count_d;
      prev_dir_q   <= prev_dir_d;
      wrap_up_q    <= wrap_up_d;
      wrap_down_q  <= wrap_down_d;
      wrap_count_q <= wrap_count_d;
      step_err_q   <= step_err_d;
`ifdef MONITOR_MINMAX_EN
      min_seen_q   <= min_seen_d;
      max_seen_q   <= max_seen_d;
`endif
    end
  end

  assign wrap_up    = wrap_up_q;
  assign wrap_down  = wrap_down_q;
  assign wrap_count = wrap_count_q;
  assign step_err   = step_err_q;
  assign armed      = (state_q == TRACK);
`ifdef MONITOR_MINMAX_EN
  assign min_seen   = min_seen_q;
  assign max_seen   = max_seen_q;
`endif

endmodule
